// File: rtl/spike_demux_3.sv
// spike_demux_3: 1-to-3 valid/ready demultiplexer for neuron-datapath samples.
// Each output owns a one-entry holding register, so a stalled consumer only
// blocks transfers addressed to it. Select code 2'b11 discards the transfer
// and bumps a saturating drop counter.
module spike_demux_3 #(
    parameter int WIDTH     = 12,
    parameter int CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [WIDTH-1:0]     in_data,
    input  logic        [1:0]           in_sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [WIDTH-1:0]     out_data_0,
    output logic signed [WIDTH-1:0]     out_data_1,
    output logic signed [WIDTH-1:0]     out_data_2,
    output logic                        out_valid_0,
    output logic                        out_valid_1,
    output logic                        out_valid_2,
    input  logic                        out_ready_0,
    input  logic                        out_ready_1,
    input  logic                        out_ready_2,
    output logic        [CNT_WIDTH-1:0] drop_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]             out_ready_s;
    logic [2:0]             slot_free_s;
    logic [2:0]             load_s;
    logic                   drop_s;
    logic                   accept_s;

    logic [2:0]             valid_q;
    logic [2:0]             valid_d;
    logic [2:0][WIDTH-1:0]  data_q;
    logic [2:0][WIDTH-1:0]  data_d;
    logic [CNT_WIDTH-1:0]   drop_q;
    logic [CNT_WIDTH-1:0]   drop_d;

    assign out_ready_s = {out_ready_2, out_ready_1, out_ready_0};
    // A slot can take new data if it is empty or is being drained this cycle.
    assign slot_free_s = ~valid_q | out_ready_s;
    assign accept_s    = in_valid & in_ready;

    // Combinational ready: drops are always accepted, otherwise follow the addressed slot.
    always_comb begin
        in_ready = 1'b0;
        case (in_sel)
            2'b00:   in_ready = slot_free_s[0];
            2'b01:   in_ready = slot_free_s[1];
            2'b10:   in_ready = slot_free_s[2];
            2'b11:   in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Decode an accepted transfer into a one-hot slot load or a drop event.
    always_comb begin
        load_s = 3'b000;
        drop_s = 1'b0;
        if (accept_s) begin
            case (in_sel)
                2'b00:   load_s = 3'b001;
                2'b01:   load_s = 3'b010;
                2'b10:   load_s = 3'b100;
                2'b11:   drop_s = 1'b1;
                default: begin
                    load_s = 3'b000;
                    drop_s = 1'b0;
                end
            endcase
        end else begin
            load_s = 3'b000;
            drop_s = 1'b0;
        end
    end

    // Next state per slot: load wins over drain so a full slot streams without bubbles.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < 3; k++) begin
            if (load_s[k]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = in_data;
            end else if (valid_q[k] && out_ready_s[k]) begin
                valid_d[k] = 1'b0;
            end else begin
                valid_d[k] = valid_q[k];
            end
        end
    end

    // Next drop count: saturating increment, never wraps.
    always_comb begin
        drop_d = drop_q;
        if (drop_s && (drop_q != CNT_MAX)) begin
            drop_d = drop_q + CNT_ONE;
        end else begin
            drop_d = drop_q;
        end
    end

    // State registers; reset discards any pending entries and clears the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 3'b000;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid_0 = valid_q[0];
    assign out_valid_1 = valid_q[1];
    assign out_valid_2 = valid_q[2];
    assign out_data_0  = data_q[0];
    assign out_data_1  = data_q[1];
    assign out_data_2  = data_q[2];
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_spike_demux_3.sv
// Scoreboard bench for spike_demux_3: per-output expected queues filled on
// accept, popped by an independent monitor when the consumer takes a sample.
module tb_spike_demux_3;

    localparam int WIDTH     = 12;
    localparam int CNT_WIDTH = 4;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic signed [WIDTH-1:0]     in_data = '0;
    logic        [1:0]           in_sel = 2'b00;
    logic                        in_valid = 1'b0;
    logic                        in_ready;
    logic signed [WIDTH-1:0]     out_data_0, out_data_1, out_data_2;
    logic                        out_valid_0, out_valid_1, out_valid_2;
    logic                        out_ready_0 = 1'b0;
    logic                        out_ready_1 = 1'b0;
    logic                        out_ready_2 = 1'b0;
    logic        [CNT_WIDTH-1:0] drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    int q0[$];
    int q1[$];
    int q2[$];
    int drop_exp = 0;
    bit rnd_on = 1'b0;

    spike_demux_3 #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_data_0(out_data_0), .out_data_1(out_data_1), .out_data_2(out_data_2),
        .out_valid_0(out_valid_0), .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
        .out_ready_0(out_ready_0), .out_ready_1(out_ready_1), .out_ready_2(out_ready_2),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsz(int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic int qfront(int k);
        case (k)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic int rdy(int k);
        case (k)
            0: return int'(out_ready_0);
            1: return int'(out_ready_1);
            default: return int'(out_ready_2);
        endcase
    endfunction

    function automatic int vld(int k);
        case (k)
            0: return int'(out_valid_0);
            1: return int'(out_valid_1);
            default: return int'(out_valid_2);
        endcase
    endfunction

    function automatic int dat(int k);
        int v;
        case (k)
            0: v = out_data_0;
            1: v = out_data_1;
            default: v = out_data_2;
        endcase
        return v;
    endfunction

    // Reference: a destination can take data when it holds nothing or its consumer takes it now.
    function automatic int exp_ready(int sel);
        if (sel == 3) return 1;
        return (qsz(sel) == 0 || rdy(sel) == 1) ? 1 : 0;
    endfunction

    // Model value of a 12-bit two's complement field carried by an int.
    function automatic int wrap12(int v);
        logic signed [WIDTH-1:0] t;
        t = v[WIDTH-1:0];
        return int'(t);
    endfunction

    task automatic push(int sel, int v);
        case (sel)
            0: q0.push_back(wrap12(v));
            1: q1.push_back(wrap12(v));
            2: q2.push_back(wrap12(v));
            default: drop_exp++;
        endcase
    endtask

    // Present one sample; entry and exit at 1 time unit after a rising edge.
    task automatic send(int sel, int v);
        bit done = 1'b0;
        bit acc;
        int waited = 0;
        in_valid = 1'b1;
        in_sel   = sel[1:0];
        in_data  = v[WIDTH-1:0];
        while (!done) begin
            @(negedge clk);
            check("in_ready", int'(in_ready), exp_ready(sel));
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin
                push(sel, v);
                done = 1'b1;
            end
            #1;
            waited++;
            if (!done && waited > 50) begin
                check("accept_timeout", 0, 1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ready(bit r0, bit r1, bit r2);
        out_ready_0 = r0;
        out_ready_1 = r1;
        out_ready_2 = r2;
    endtask

    task automatic check_cleared(string tag);
        check({tag, "_valid0"}, int'(out_valid_0), 0);
        check({tag, "_valid1"}, int'(out_valid_1), 0);
        check({tag, "_valid2"}, int'(out_valid_2), 0);
        check({tag, "_data0"}, int'(out_data_0), 0);
        check({tag, "_data1"}, int'(out_data_1), 0);
        check({tag, "_data2"}, int'(out_data_2), 0);
        check({tag, "_drop"}, int'(drop_count), 0);
    endtask

    // Monitor: compare outputs against the scoreboard mid-cycle, retire drained entries at the edge.
    initial begin : monitor
        bit [2:0] drain;
        forever begin
            @(negedge clk);
            drain = 3'b000;
            if (rst_n) begin
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("out_valid_%0d", k), vld(k), (qsz(k) > 0) ? 1 : 0);
                    if (vld(k) == 1 && qsz(k) > 0) begin
                        check($sformatf("out_data_%0d", k), dat(k), qfront(k));
                        if (rdy(k) == 1) drain[k] = 1'b1;
                    end
                end
                check("drop_count", int'(drop_count), (drop_exp > CNT_MAX) ? CNT_MAX : drop_exp);
            end
            @(posedge clk);
            if (rst_n) begin
                if (drain[0]) void'(q0.pop_front());
                if (drain[1]) void'(q1.pop_front());
                if (drain[2]) void'(q2.pop_front());
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        time t0;
        #2;
        check_cleared("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic routing, all consumers ready.
        set_ready(1'b1, 1'b1, 1'b1);
        send(0, -5);
        send(1, 100);
        send(2, -2048);
        idle(2);

        // Back-pressure isolation on slot 1.
        set_ready(1'b1, 1'b0, 1'b1);
        send(1, 7);
        fork
            begin
                send(1, 9);
                send(0, 3);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready_1 = 1'b1;
            end
        join
        idle(2);

        // Full throughput on slot 2.
        set_ready(1'b1, 1'b1, 1'b1);
        t0 = $time;
        for (int i = 0; i < 32; i++) send(2, i);
        check("throughput_cycles", int'(($time - t0) / 10), 32);
        idle(2);

        // Drops with saturation.
        for (int i = 0; i < 20; i++) send(3, i);
        idle(1);
        check("drop_saturated", int'(drop_count), CNT_MAX);

        // Simultaneous drain and load on slot 0.
        set_ready(1'b0, 1'b1, 1'b1);
        send(0, 11);
        idle(1);
        out_ready_0 = 1'b1;
        send(0, 22);
        idle(2);

        // Randomized traffic with random consumer back-pressure.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    out_ready_0 = ($urandom_range(0, 3) != 0);
                    out_ready_1 = ($urandom_range(0, 3) != 0);
                    out_ready_2 = ($urandom_range(0, 1) != 0);
                    @(posedge clk);
                    #1;
                end
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    send(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)) - 2048);
                    if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
                end
                rnd_on = 1'b0;
            end
        join
        set_ready(1'b1, 1'b1, 1'b1);
        idle(3);

        // Reset mid-stream with all slots full and stalled.
        set_ready(1'b0, 1'b0, 1'b0);
        send(0, 123);
        send(1, -77);
        send(2, 512);
        idle(1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        drop_exp = 0;
        #1;
        check_cleared("midreset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_ready(1'b1, 1'b1, 1'b1);
        send(1, -1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_demux_3.md
Name: spike_demux_3

Overview:
- Sequential 1-to-3 demultiplexer with valid/ready handshakes. It is the distribution-side counterpart of the 3-way select mux on the neuron datapath.
- Routes signed WIDTH-bit samples, such as membrane potentials or spike-event payloads, from one upstream producer to one of three downstream consumers, chosen per transfer by a 2-bit select.
- Each output has its own one-entry holding register. A stalled consumer blocks only the transfers addressed to it.
- Select code 2'b11 discards the transfer and counts it.

Parameters:
- WIDTH, 12, data width in bits (signed two's complement).
- CNT_WIDTH, 8, width of the drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  signed input sample.
- in_sel  input  2  destination: 00 -> out 0, 01 -> out 1, 10 -> out 2, 11 -> drop.
- in_valid  input  1  upstream has a sample.
- in_ready  output  1  block can accept this cycle.
- out_data_0 / out_data_1 / out_data_2  output  WIDTH each  signed output samples.
- out_valid_0 / out_valid_1 / out_valid_2  output  1 each  output register k holds a sample.
- out_ready_0 / out_ready_1 / out_ready_2  input  1 each  consumer k accepts.
- drop_count  output  CNT_WIDTH  number of transfers discarded via sel=11.

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous deassert expected at system level):
  - all out_valid_k=0, all out_data_k=0, drop_count=0.
  - Any pending entries are discarded on reset mid-operation; no partial transfer survives.
- Slot k is free when out_valid_k=0 OR out_ready_k=1 (drained this cycle).
- in_ready is combinational:
  - in_sel=11 -> 1.
  - otherwise -> free(slot selected by in_sel).
  - It depends on the current in_sel and out_ready_k; there is no registered path from in_valid to in_ready.
- Accept: a transfer occurs when in_valid=1 AND in_ready=1 at the rising clk edge.
  - sel=k (k<3): out_data_k <= in_data and out_valid_k <= 1 at that edge. Latency is 1 cycle from accept to out_valid_k visible.
  - sel=11: nothing is written; drop_count increments by 1 and saturates at 2^CNT_WIDTH-1 (no wrap).
- Output drain: at an edge with out_valid_k=1 AND out_ready_k=1 and no new accept into k, out_valid_k <= 0. out_data_k keeps its last value; it is don't-care while out_valid_k=0 but must not be X.
- Simultaneous drain and accept on the same slot k: new data is loaded and out_valid_k stays 1. This gives full throughput of 1 sample/cycle per output with no bubble.
- Stall: while out_valid_k=1 AND out_ready_k=0, out_data_k is held stable and out_valid_k is held at 1.
- Independence: slots operate in parallel.
  - A full, stalled slot blocks only inputs with in_sel pointing at it.
  - Other slots continue to drain while it is blocked.
  - At most one slot is written per cycle.
- Upstream contract: in_data and in_sel are held stable while in_valid=1 AND in_ready=0. The block does not check this; the bench asserts it.
- Arithmetic: data passes through bit-exact with no sign extension or truncation. The counter is unsigned.
- in_valid=0: no state change except drains.
- Block-level state per slot is one valid flag plus one data register: EMPTY (valid=0) and FULL (valid=1) transitions follow the accept/drain rules above.

Test Plan:
- Reset mid-stream: fill all three slots with out_ready_k=0, then pulse rst_n low asynchronously (off-edge) -> out_valid_0..2=0, out_data_0..2=0 and drop_count=0 immediately, not waiting for a clk edge.
- Basic routing: send -5 with sel=00, 100 with sel=01, -2048 with sel=10 on consecutive cycles, all out_ready=1 -> each appears on its own output exactly one cycle after its accept, and in_ready stays 1 throughout.
- Back-pressure isolation: hold out_ready_1=0, send 7 with sel=01 then 9 with sel=01 then 3 with sel=00.
  - out_data_1=7 is held.
  - in_ready=0 while 9 is presented.
  - Upstream holds 9, so 3 cannot be presented until 9 is accepted.
  - Release out_ready_1 -> 9 is accepted in that same cycle and appears next cycle; 3 follows with no extra bubble.
- Full throughput: stream 0,1,2,...,31 all with sel=10 and out_ready_2=1 -> one sample per cycle on out 2 in order, with no bubble and out_valid_2 held at 1.
- Drop and saturation: with CNT_WIDTH=4, send 20 transfers with sel=11 -> in_ready=1 every cycle, no out_valid asserted, drop_count reaches 15 and stays at 15.
- Simultaneous drain and load: slot 0 is full with 11 and out_ready_0=1 in the same cycle that 22 is accepted with sel=00 -> the consumer takes 11, then out_data_0=22 with out_valid_0 continuously 1.
